// File: rtl/rpn_pkg.sv
// Shared opcode, error-code and state definitions for the RPN expression sequencer.
package rpn_pkg;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_PUSH = 3'b110;
  localparam logic [2:0] OP_POP  = 3'b111;

  localparam logic [1:0] ERR_OK    = 2'b00;
  localparam logic [1:0] ERR_UNDER = 2'b01;
  localparam logic [1:0] ERR_FULL  = 2'b10;
  localparam logic [1:0] ERR_DEPTH = 2'b11;

  typedef enum logic [2:0] {
    IDLE, EXEC, CHECK, FPOP, FCHK, FLUSH, DRAIN, DONE
  } state_e;

endpackage

// File: rtl/rpn_sequencer.sv
// Evaluates one RPN expression per result record by driving a stack-based ALU.
// Optional RPN_OVF_ABORT_EN: ALU overflow aborts the expression with a stack/ALU error.
module rpn_sequencer
  import rpn_pkg::*;
#(
  parameter int N        = 4,
  parameter int MAX_SIZE = 1024
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tok_valid,
  output logic         tok_ready,
  input  logic         tok_is_op,
  input  logic [N-1:0] tok_data,
  input  logic         tok_last,
  output logic [2:0]   alu_opcode,
  output logic [N-1:0] alu_input_data,
  input  logic [N-1:0] alu_output_data,
  input  logic         alu_overflow,
  input  logic         alu_success,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [N-1:0] res_data,
  output logic         res_overflow,
  output logic [1:0]   res_err
);

  localparam int DW = $clog2(MAX_SIZE + 1);
  localparam logic [DW-1:0] DEPTH_MAX = DW'(MAX_SIZE);

  state_e         state_q, state_d;
  logic [DW-1:0]  depth_q, depth_d;
  logic           is_op_q, is_op_d;
  logic           mul_q, mul_d;
  logic [N-1:0]   data_q, data_d;
  logic           last_q, last_d;
  logic [N-1:0]   res_data_q, res_data_d;
  logic           res_ovf_q, res_ovf_d;
  logic [1:0]     res_err_q, res_err_d;
  logic           ovf_abort;

`ifdef RPN_OVF_ABORT_EN
  assign ovf_abort = alu_overflow;
`else
  assign ovf_abort = 1'b0;
`endif

  // NOTE: every output and next-state signal gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d        = state_q;
    depth_d        = depth_q;
    is_op_d        = is_op_q;
    mul_d          = mul_q;
    data_d         = data_q;
    last_d         = last_q;
    res_data_d     = res_data_q;
    res_ovf_d      = res_ovf_q;
    res_err_d      = res_err_q;
    tok_ready      = 1'b0;
    alu_opcode     = OP_NOP;
    alu_input_data = '0;
    res_valid      = 1'b0;

    case (state_q)
      IDLE: begin
        tok_ready = 1'b1;
        if (tok_valid) begin
          is_op_d = tok_is_op;
          mul_d   = tok_data[0];
          data_d  = tok_data;
          last_d  = tok_last;
          if (tok_is_op && depth_q < DW'(2)) begin
            res_err_d = ERR_UNDER;
            state_d   = tok_last ? DRAIN : FLUSH;
          end else if (!tok_is_op && depth_q == DEPTH_MAX) begin
            res_err_d = ERR_FULL;
            state_d   = tok_last ? DRAIN : FLUSH;
          end else begin
            state_d = EXEC;
          end
        end
      end
      EXEC: begin
        if (is_op_q) begin
          alu_opcode = mul_q ? OP_MUL : OP_ADD;
          depth_d    = depth_q - DW'(1);
        end else begin
          alu_opcode     = OP_PUSH;
          alu_input_data = data_q;
          depth_d        = depth_q + DW'(1);
        end
        state_d = CHECK;
      end
      CHECK: begin
        res_ovf_d = res_ovf_q | alu_overflow;
        if (!alu_success || ovf_abort) begin
          res_err_d = ERR_FULL;
          state_d   = last_q ? DRAIN : FLUSH;
        end else if (last_q) begin
          if (depth_q == DW'(1)) begin
            state_d = FPOP;
          end else begin
            res_err_d = ERR_DEPTH;
            state_d   = DRAIN;
          end
        end else begin
          state_d = IDLE;
        end
      end
      FPOP: begin
        alu_opcode = OP_POP;
        depth_d    = '0;
        state_d    = FCHK;
      end
      FCHK: begin
        if (alu_success) begin
          res_data_d = alu_output_data;
        end else begin
          res_data_d = '0;
          res_err_d  = ERR_FULL;
        end
        state_d = DONE;
      end
      FLUSH: begin
        tok_ready = 1'b1;
        if (tok_valid && tok_last) state_d = DRAIN;
      end
      DRAIN: begin
        // Unwind whatever the aborted expression left on the ALU stack.
        if (depth_q != '0) begin
          alu_opcode = OP_POP;
          depth_d    = depth_q - DW'(1);
        end else begin
          res_data_d = '0;
          state_d    = DONE;
        end
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) begin
          res_ovf_d = 1'b0;
          res_err_d = ERR_OK;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      depth_q    <= '0;
      is_op_q    <= 1'b0;
      mul_q      <= 1'b0;
      data_q     <= '0;
      last_q     <= 1'b0;
      res_data_q <= '0;
      res_ovf_q  <= 1'b0;
      res_err_q  <= ERR_OK;
    end else begin
      state_q    <= state_d;
      depth_q    <= depth_d;
      is_op_q    <= is_op_d;
      mul_q      <= mul_d;
      data_q     <= data_d;
      last_q     <= last_d;
      res_data_q <= res_data_d;
      res_ovf_q  <= res_ovf_d;
      res_err_q  <= res_err_d;
    end
  end

  assign res_data     = res_data_q;
  assign res_overflow = res_ovf_q;
  assign res_err      = res_err_q;

endmodule

// File: doc/rpn_sequencer.md
Name: rpn_sequencer

Overview:
- Controller that evaluates one reverse-Polish expression at a time on the stack-based ALU (N-bit signed, MAX_SIZE deep).
- Accepts a stream of operand/operator tokens over a valid/ready handshake and issues PUSH/ADD/MUL/POP opcodes to the ALU one at a time.
- Checks ALU success/overflow after every opcode, pops the final result, and returns a result/status record.
- Sits between the command front-end and STACK_BASED_ALU; it is the ALU's only opcode source.

Parameters:
N, 4, operand/result width (signed)
MAX_SIZE, 1024, ALU stack depth; sizes the internal depth counter ($clog2(MAX_SIZE+1) bits)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
tok_valid  in  1  token valid
tok_ready  out  1  token accepted when tok_valid&&tok_ready
tok_is_op  in  1  1 = operator, 0 = operand
tok_data  in  N  operand value (signed); for operators bit0: 0=ADD, 1=MUL, other bits ignored
tok_last  in  1  last token of expression
alu_opcode  out  3  to ALU: 000 NOP, 100 ADD, 101 MUL, 110 PUSH, 111 POP
alu_input_data  out  N  to ALU input_data
alu_output_data  in  N  from ALU output_data
alu_overflow  in  1  from ALU overflow
alu_success  in  1  from ALU success
res_valid  out  1  result record valid
res_ready  in  1  result consumed when res_valid&&res_ready
res_data  out  N  signed result; 0 on error
res_overflow  out  1  sticky OR of alu_overflow over the expression
res_err  out  2  00 ok, 01 operator underflow, 10 stack full / ALU fail, 11 final depth != 1

Behaviour:
- Reset values: state IDLE; depth 0; tok_ready 1; alu_opcode 000; alu_input_data 0; res_valid 0; res_data 0; res_overflow 0; res_err 00.
- Reset mid-expression aborts everything. The ALU shares rst, so its stack is also empty.
- alu_opcode is 000 in every state not listed below as driving an opcode.
- States: IDLE, EXEC, CHECK, FPOP, FCHK, FLUSH, DRAIN, DONE.
- IDLE: tok_ready=1. On accept, register the token and last flag.
  - Pre-check, no opcode issued: operator with depth<2 sets err=01; operand with depth==MAX_SIZE sets err=10.
  - Pre-check fail: go to FLUSH, or to DRAIN if tok_last.
  - Otherwise go to EXEC.
- EXEC (1 cycle): drive PUSH with alu_input_data=token, or ADD/MUL. Depth +1 for PUSH, -1 for an operator. Go to CHECK.
- CHECK: sample ALU outputs registered at the EXEC edge.
  - res_overflow |= alu_overflow.
  - alu_success==0: err=10; go to FLUSH, or DRAIN if last.
  - Else if last: depth==1 goes to FPOP; otherwise err=11 and go to DRAIN.
  - Else go to IDLE.
- Throughput: one token per 3 cycles.
- FPOP: drive POP; depth to 0. FCHK: capture res_data=alu_output_data. alu_success==0 sets err=10 and res_data=0. Go to DONE.
- FLUSH: tok_ready=1. Discard tokens until a tok_last token is accepted, then go to DRAIN.
- DRAIN: drive POP once per cycle while depth>0, decrementing depth; results ignored. At depth 0 go to DONE with res_data=0.
- DONE: res_valid=1, and all res_* are held stable until res_ready. Then clear res_overflow/res_err and go to IDLE. tok_ready=0 throughout.
- Arithmetic is performed by the ALU only. The result is the ALU's N-bit truncated value; no width extension is done here.

Optional Feature:
RPN_OVF_ABORT_EN
- Defined: alu_overflow=1 in CHECK is treated as an error. Set err=10, res_overflow=1, and go to FLUSH/DRAIN as for an ALU fail; res_data=0.
- Undefined: overflow only sets the sticky res_overflow. Evaluation continues and res_data is the truncated value.

Decomposition:
- Package rpn_pkg holds:
  - opcode constants OP_NOP/OP_ADD/OP_MUL/OP_PUSH/OP_POP;
  - err constants ERR_OK/ERR_UNDER/ERR_FULL/ERR_DEPTH;
  - the state enum.
- Single module; no sub-module needed. The depth counter is inline.

Test Plan:
- Tokens 3, 4, ADD(last) -> res_data=7, res_overflow=0, res_err=00; alu_opcode sequence 110,110,100,111.
- Tokens 3, -2, MUL(last) -> res_data=-6, res_err=00.
- N=4, tokens 7, 7, ADD(last), macro undefined -> res_data=-2, res_overflow=1, res_err=00. Same stimulus with RPN_OVF_ABORT_EN -> res_data=0, res_err=10.
- Tokens ADD, 5, 6(last) -> err=01 at the first token, no opcode issued, 5 and 6 flushed without PUSH, then res_err=01, res_data=0.
- Tokens 1, 2(last) -> res_err=11, two DRAIN POPs issued, depth 0. A following expression 2, 2, MUL(last) -> res_data=4.
- res_ready held low 10 cycles in DONE -> res_* stable, tok_ready=0. Assert rst mid-EXEC -> all outputs return to reset values immediately.
